// File: rtl/z_core_pkg.sv
// Shared Z-Core definitions: datapath width and ALU operation codes.
// The decoder and the ALU both import this package.
package z_core_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_BEQ  = 4'd10;
  localparam logic [3:0] ALU_BNE  = 4'd11;
  localparam logic [3:0] ALU_BLT  = 4'd12;
  localparam logic [3:0] ALU_BGE  = 4'd13;
  localparam logic [3:0] ALU_BLTU = 4'd14;
  localparam logic [3:0] ALU_BGEU = 4'd15;

endpackage

// File: rtl/z_core_alu_cmp.sv
// Combinational operand comparator shared by SLT/SLTU and all branch conditions.
module z_core_alu_cmp
  import z_core_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            eq,
  output logic            lt_signed,
  output logic            lt_unsigned
);

  assign eq          = (a == b);
  assign lt_signed   = ($signed(a) < $signed(b));
  assign lt_unsigned = (a < b);

endmodule

// File: rtl/z_core_alu.sv
// Z-Core RV32I integer ALU: result and branch-taken flag, both registered
// with one cycle of latency and a synchronous active-high reset.
module z_core_alu
  import z_core_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] alu_in1,
  input  logic [XLEN-1:0] alu_in2,
  input  logic [3:0]      alu_inst_type,
  output logic [XLEN-1:0] alu_out,
  output logic            alu_branch
);

  logic            eq;
  logic            lt_signed;
  logic            lt_unsigned;
  logic [4:0]      shamt;
  logic [XLEN-1:0] result;
  logic            branch;

  z_core_alu_cmp u_cmp (
    .a           (alu_in1),
    .b           (alu_in2),
    .eq          (eq),
    .lt_signed   (lt_signed),
    .lt_unsigned (lt_unsigned)
  );

  // Only the low five bits of B are a shift amount; the rest are ignored.
  assign shamt = alu_in2[4:0];

  always_comb begin
    // NOTE: defaults first so every path assigns result/branch and no latch is inferred.
    result = '0;
    branch = 1'b0;
    case (alu_inst_type)
      ALU_ADD:  result = alu_in1 + alu_in2;
      ALU_SUB:  result = alu_in1 - alu_in2;
      ALU_SLL:  result = alu_in1 << shamt;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt_signed};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, lt_unsigned};
      ALU_XOR:  result = alu_in1 ^ alu_in2;
      ALU_SRL:  result = alu_in1 >> shamt;
      ALU_SRA:  result = $signed(alu_in1) >>> shamt;
      ALU_OR:   result = alu_in1 | alu_in2;
      ALU_AND:  result = alu_in1 & alu_in2;
      ALU_BEQ:  branch = eq;
      ALU_BNE:  branch = !eq;
      ALU_BLT:  branch = lt_signed;
      ALU_BGE:  branch = !lt_signed;
      ALU_BLTU: branch = lt_unsigned;
      ALU_BGEU: branch = !lt_unsigned;
    endcase
  end

  // NOTE: non-blocking assignments for registered state so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out    <= '0;
      alu_branch <= 1'b0;
    end else begin
      alu_out    <= result;
      alu_branch <= branch;
    end
  end

endmodule

// File: tb/tb_z_core_alu.sv
// Self-checking bench for z_core_alu: directed cases plus randomized
// back-to-back traffic against an arithmetic reference model.
module tb_z_core_alu;
  import z_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [3:0]  alu_inst_type;
  logic [31:0] alu_out;
  logic        alu_branch;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  z_core_alu dut (
    .clk           (clk),
    .rst           (rst),
    .alu_in1       (alu_in1),
    .alu_in2       (alu_in2),
    .alu_inst_type (alu_inst_type),
    .alu_out       (alu_out),
    .alu_branch    (alu_branch)
  );

  // Reference model built from integer arithmetic on 64-bit values.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic br);
    longint m  = 64'sh1_0000_0000;
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint p  = longint'(1) << (ub % 32);
    longint q;
    r  = 32'd0;
    br = 1'b0;
    case (op)
      4'd0:  r = 32'((ua + ub) % m);
      4'd1:  r = 32'((ua - ub + m) % m);
      4'd2:  r = 32'((ua * p) % m);
      4'd3:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd4:  r = (ua < ub) ? 32'd1 : 32'd0;
      4'd5:  r = a ^ b;
      4'd6:  r = 32'(ua / p);
      4'd7:  begin
        q = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
        r = 32'(q);
      end
      4'd8:  r = a | b;
      4'd9:  r = a & b;
      4'd10: br = (ua == ub);
      4'd11: br = (ua != ub);
      4'd12: br = (sa < sb);
      4'd13: br = (sa >= sb);
      4'd14: br = (ua < ub);
      default: br = (ua >= ub);
    endcase
  endfunction

  // Present one operation and step to just after the capturing edge.
  task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_inst_type = op;
    alu_in1       = a;
    alu_in2       = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    alu_in1 = 32'd5;
    alu_in2 = 32'd3;
    alu_inst_type = ALU_ADD;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (alu_out !== 32'd0 || alu_branch !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got out=%h br=%b, expected out=00000000 br=0", i, alu_out, alu_branch);
      end
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (alu_out !== 32'd8 || alu_branch !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got out=%h br=%b, expected out=00000008 br=0", alu_out, alu_branch);
    end
  endtask

  task automatic test_arith_logic;
    logic [3:0]  ops [7] = '{ALU_ADD, ALU_SUB, ALU_SUB, ALU_ADD, ALU_XOR, ALU_OR, ALU_AND};
    logic [31:0] as  [7] = '{32'd2, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd12, 32'd12, 32'd12};
    logic [31:0] bs  [7] = '{32'd3, 32'd3, 32'd1, 32'd1, 32'd5, 32'd5, 32'd5};
    logic [31:0] exp [7] = '{32'd5, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd9, 32'd13, 32'd4};
    for (int i = 0; i < 7; i++) begin
      apply(ops[i], as[i], bs[i]);
      n_tests++;
      if (alu_out !== exp[i] || alu_branch !== 1'b0) begin
        n_fail++;
        $display("FAIL arith[%0d] op=%0d: got out=%h br=%b, expected out=%h br=0", i, ops[i], alu_out, alu_branch, exp[i]);
      end
    end
  endtask

  task automatic test_shifts;
    logic [3:0]  ops [6] = '{ALU_SLL, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SRL, ALU_SLL};
    logic [31:0] as  [6] = '{32'd2, 32'd2, 32'd12, 32'h8000_0000, 32'h8000_0000, 32'h8000_0003};
    logic [31:0] bs  [6] = '{32'd1, 32'd8, 32'd2, 32'd4, 32'd4, 32'd33};
    logic [31:0] exp [6] = '{32'd4, 32'd512, 32'd3, 32'hF800_0000, 32'h0800_0000, 32'h0000_0006};
    for (int i = 0; i < 6; i++) begin
      apply(ops[i], as[i], bs[i]);
      n_tests++;
      if (alu_out !== exp[i] || alu_branch !== 1'b0) begin
        n_fail++;
        $display("FAIL shift[%0d] op=%0d: got out=%h br=%b, expected out=%h br=0", i, ops[i], alu_out, alu_branch, exp[i]);
      end
    end
  endtask

  task automatic test_compares;
    logic [3:0]  ops [4] = '{ALU_SLT, ALU_SLTU, ALU_SLT, ALU_SLTU};
    logic [31:0] as  [4] = '{32'd10, 32'd20, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs  [4] = '{32'd20, 32'd10, 32'd1, 32'd1};
    logic [31:0] exp [4] = '{32'd1, 32'd0, 32'd1, 32'd0};
    for (int i = 0; i < 4; i++) begin
      apply(ops[i], as[i], bs[i]);
      n_tests++;
      if (alu_out !== exp[i] || alu_branch !== 1'b0) begin
        n_fail++;
        $display("FAIL compare[%0d] op=%0d: got out=%h br=%b, expected out=%h br=0", i, ops[i], alu_out, alu_branch, exp[i]);
      end
    end
  endtask

  task automatic test_branches;
    logic [3:0]  ops [6] = '{ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};
    logic [31:0] as  [6] = '{32'd7, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5};
    logic [31:0] bs  [6] = '{32'd7, 32'd7, 32'd0, 32'd0, 32'd0, 32'd5};
    logic        exp [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      apply(ops[i], as[i], bs[i]);
      n_tests++;
      if (alu_out !== 32'd0 || alu_branch !== exp[i]) begin
        n_fail++;
        $display("FAIL branch[%0d] op=%0d: got out=%h br=%b, expected out=00000000 br=%b", i, ops[i], alu_out, alu_branch, exp[i]);
      end
    end
  endtask

  task automatic test_mid_reset;
    apply(ALU_ADD, 32'd1, 32'd1);
    n_tests++;
    if (alu_out !== 32'd2) begin
      n_fail++;
      $display("FAIL mid_reset_pre: got out=%h, expected out=00000002", alu_out);
    end
    rst = 1'b1;
    apply(ALU_BEQ, 32'd7, 32'd7);
    n_tests++;
    if (alu_out !== 32'd0 || alu_branch !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_discard: got out=%h br=%b, expected out=00000000 br=0", alu_out, alu_branch);
    end
    rst = 1'b0;
    apply(ALU_ADD, 32'd7, 32'd7);
    n_tests++;
    if (alu_out !== 32'd14 || alu_branch !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_resume: got out=%h br=%b, expected out=0000000e br=0", alu_out, alu_branch);
    end
  endtask

  // New opcode and operands every cycle; each edge's output is checked against the inputs it captured.
  task automatic run_stream(input string name, input int cycles, input bit sweep);
    logic [3:0]  op;
    logic [31:0] a, b, exp_r;
    logic        exp_b;
    for (int i = 0; i < cycles; i++) begin
      op = sweep ? 4'(i) : 4'($urandom_range(0, 15));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = $urandom_range(0, 70);
        default: b = $urandom;
      endcase
      model(op, a, b, exp_r, exp_b);
      apply(op, a, b);
      n_tests++;
      if (alu_out !== exp_r || alu_branch !== exp_b) begin
        n_fail++;
        $display("FAIL %s[%0d] op=%0d a=%h b=%h: got out=%h br=%b, expected out=%h br=%b",
                 name, i, op, a, b, alu_out, alu_branch, exp_r, exp_b);
      end
    end
  endtask

  task automatic test_back_to_back;
    run_stream("back_to_back", 16, 1'b1);
  endtask

  task automatic test_random;
    run_stream("random", 400, 1'b0);
  endtask

  initial begin
    test_reset();
    test_arith_logic();
    test_shifts();
    test_compares();
    test_branches();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
